// File: rtl/obi_axi_master_if.sv
// OBI request/response port plus single-beat AXI4 master channels of the bridge.
// "master" is the bridge's view; "slave" is the core/interconnect side driving it.
interface obi_axi_master_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 16
);
  logic           obi_req_i;
  logic           obi_gnt_o;
  logic [AW-1:0]  obi_addr_i;
  logic           obi_we_i;
  logic [3:0]     obi_be_i;
  logic [DW-1:0]  obi_wdata_i;
  logic           obi_rvalid_o;
  logic [DW-1:0]  obi_rdata_o;
  logic           obi_err_o;

  logic [IDW-1:0] m_axi_awid;
  logic [AW-1:0]  m_axi_awaddr;
  logic [7:0]     m_axi_awlen;
  logic [2:0]     m_axi_awsize;
  logic [1:0]     m_axi_awburst;
  logic           m_axi_awlock;
  logic [3:0]     m_axi_awcache;
  logic [2:0]     m_axi_awprot;
  logic           m_axi_awvalid;
  logic           m_axi_awready;
  logic [DW-1:0]  m_axi_wdata;
  logic [3:0]     m_axi_wstrb;
  logic           m_axi_wlast;
  logic           m_axi_wvalid;
  logic           m_axi_wready;
  logic [IDW-1:0] m_axi_bid;
  logic [1:0]     m_axi_bresp;
  logic           m_axi_bvalid;
  logic           m_axi_bready;
  logic [IDW-1:0] m_axi_arid;
  logic [AW-1:0]  m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_arlock;
  logic [3:0]     m_axi_arcache;
  logic [2:0]     m_axi_arprot;
  logic           m_axi_arvalid;
  logic           m_axi_arready;
  logic [IDW-1:0] m_axi_rid;
  logic [DW-1:0]  m_axi_rdata;
  logic [1:0]     m_axi_rresp;
  logic           m_axi_rlast;
  logic           m_axi_rvalid;
  logic           m_axi_rready;

  modport master (
    input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
    output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
    input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/obi_axi_master.sv
// OBI to AXI4 bridge: each granted OBI request becomes one single-beat AXI4
// transaction, with at most one transaction outstanding.
module obi_axi_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 16,
  parameter int AXI_ID         = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  obi_axi_master_if.master  bus
);
  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  state_t                    r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [3:0]                r_be;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic r_aw_done, r_w_done;
  logic r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_rvalid, r_err;

  logic w_gnt, w_aw_fin, w_w_fin;
  logic w_unused;

  assign w_gnt    = (r_state == IDLE) && bus.obi_req_i;
  // A channel counts as finished if it already handshook or handshakes this cycle.
  assign w_aw_fin = r_aw_done || (r_awvalid && bus.m_axi_awready);
  assign w_w_fin  = r_w_done  || (r_wvalid  && bus.m_axi_wready);
  assign w_unused = ^{bus.m_axi_bid, bus.m_axi_rid, bus.m_axi_rlast};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt) begin
          r_addr  <= bus.obi_addr_i;
          r_be    <= bus.obi_be_i;
          r_wdata <= bus.obi_wdata_i;
          if (bus.obi_we_i) begin
            r_state   <= WRITE;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_state   <= RD_ADDR;
            r_arvalid <= 1'b1;
          end
        end
        WRITE: begin
          if (r_awvalid && bus.m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && bus.m_axi_wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_state  <= WR_RESP;
            r_bready <= 1'b1;
          end
        end
        WR_RESP: if (bus.m_axi_bvalid) begin
          r_bready <= 1'b0;
          r_err    <= (bus.m_axi_bresp != 2'b00);
          r_rdata  <= '0;
          r_rvalid <= 1'b1;
          r_state  <= RESP;
        end
        RD_ADDR: if (bus.m_axi_arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= RD_DATA;
        end
        RD_DATA: if (bus.m_axi_rvalid) begin
          r_rready <= 1'b0;
          r_err    <= (bus.m_axi_rresp != 2'b00);
          r_rdata  <= bus.m_axi_rdata;
          r_rvalid <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          r_rvalid <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.obi_gnt_o    = w_gnt;
  assign bus.obi_rvalid_o = r_rvalid;
  assign bus.obi_rdata_o  = r_rdata;
  assign bus.obi_err_o    = r_err;

  assign bus.m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
  assign bus.m_axi_awaddr  = {r_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = 3'b010;
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = 4'b0000;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = r_be;
  assign bus.m_axi_wlast   = 1'b1;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_bready  = r_bready;

  assign bus.m_axi_arid    = AXI_ID_WIDTH'(AXI_ID);
  assign bus.m_axi_araddr  = {r_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = 3'b010;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'b0000;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;
endmodule
